// File: rtl/jtcps1_snd_mix.sv
// CPS1 sound output stage: per-frame DC-blocking high-pass followed by
// master gain with saturation, producing a registered stereo pair plus a
// one-clock valid pulse.
// Build option: define JTCPS1_SNDMIX_DCBLOCK_EN to enable the DC blocker;
// when undefined the DC states pass the input through unchanged.
module jtcps1_snd_mix #(
  parameter int DCSH     = 8,
  parameter int GAINFRAC = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sample,
  input  logic signed [15:0] left_in,
  input  logic signed [15:0] right_in,
  input  logic        [7:0]  gain,
  input  logic               mute,
  output logic signed [15:0] left,
  output logic signed [15:0] right,
  output logic               sample_out,
  output logic               clip
);

  localparam int AW = 16 + DCSH;

  typedef enum logic [2:0] {IDLE, L_DC, L_GAIN, R_DC, R_GAIN, OUT} state_t;

  state_t state, state_nx;

  logic               smp_cur, smp_prev;
  logic               start;
  logic signed [15:0] xl, xr;
  logic        [7:0]  g;
  logic signed [15:0] dc_x;
  logic signed [16:0] y_dc;
  logic signed [16:0] yl, yr;
  logic signed [16:0] mul_y;
  logic signed [25:0] my_ext, g_ext, p, q;
  logic signed [15:0] sat_v;
  logic               sat_ovf;
  logic signed [15:0] sl, sr;
  logic               cl, cr;

  assign start = smp_cur & ~smp_prev & (state == IDLE);
  assign dc_x  = (state == R_DC) ? xr : xl;

  // Sample strobe edge registers, FSM state and frame input latches
  always_ff @(posedge clk) begin
    if (rst) begin
      smp_cur  <= 1'b0;
      smp_prev <= 1'b0;
      state    <= IDLE;
      xl       <= '0;
      xr       <= '0;
      g        <= '0;
    end else begin
      smp_cur  <= sample;
      smp_prev <= smp_cur;
      state    <= state_nx;
      if (start) begin
        xl <= left_in;
        xr <= right_in;
        g  <= gain;
      end
    end
  end

  // Next-state sequencing: one clock per processing step
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = L_DC;
      L_DC:    state_nx = L_GAIN;
      L_GAIN:  state_nx = R_DC;
      R_DC:    state_nx = R_GAIN;
      R_GAIN:  state_nx = OUT;
      OUT:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

`ifdef JTCPS1_SNDMIX_DCBLOCK_EN
  logic signed [AW-1:0] acc_l, acc_r;
  logic signed [AW-1:0] dc_acc;
  logic signed [15:0]   dc_v;
  logic signed [AW-1:0] y_ext;

  // One subtractor shared by both channels; the accumulator is selected by state
  always_comb begin
    dc_acc = (state == R_DC) ? acc_r : acc_l;
    dc_v   = 16'(dc_acc >>> DCSH);
    y_dc   = {dc_x[15], dc_x} - {dc_v[15], dc_v};
    y_ext  = {{(AW-17){y_dc[16]}}, y_dc};
  end

  // Leaky integrators tracking the DC level of each channel
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_l <= '0;
      acc_r <= '0;
    end else begin
      if (state == L_DC) acc_l <= acc_l + y_ext;
      if (state == R_DC) acc_r <= acc_r + y_ext;
    end
  end
`else
  // DC stage is a pass-through: sign-extend the input
  always_comb begin
    y_dc = {dc_x[15], dc_x};
  end
`endif

  // Single time-shared multiplier followed by floor shift and saturation
  always_comb begin
    mul_y   = (state == R_GAIN) ? yr : yl;
    my_ext  = {{9{mul_y[16]}}, mul_y};
    g_ext   = {18'd0, g};
    p       = my_ext * g_ext;
    q       = p >>> GAINFRAC;
    sat_ovf = 1'b0;
    sat_v   = q[15:0];
    if (q > 26'sd32767) begin
      sat_v   = 16'sh7fff;
      sat_ovf = 1'b1;
    end else if (q < -26'sd32768) begin
      sat_v   = 16'sh8000;
      sat_ovf = 1'b1;
    end
  end

  // Per-channel intermediate results and the registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      yl         <= '0;
      yr         <= '0;
      sl         <= '0;
      sr         <= '0;
      cl         <= 1'b0;
      cr         <= 1'b0;
      left       <= '0;
      right      <= '0;
      clip       <= 1'b0;
      sample_out <= 1'b0;
    end else begin
      sample_out <= 1'b0;
      case (state)
        L_DC:   yl <= y_dc;
        R_DC:   yr <= y_dc;
        L_GAIN: begin sl <= sat_v; cl <= sat_ovf; end
        R_GAIN: begin sr <= sat_v; cr <= sat_ovf; end
        OUT: begin
          left       <= mute ? '0 : sl;
          right      <= mute ? '0 : sr;
          clip       <= cl | cr;
          sample_out <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jtcps1_snd_mix.sv
// Self-checking bench for jtcps1_snd_mix: randomized and directed frames
// compared against an arithmetic model of the DC blocker and gain stage.
module tb_jtcps1_snd_mix;

  localparam int DCSH     = 8;
  localparam int GAINFRAC = 6;

  logic               clk = 1'b0;
  logic               rst;
  logic               sample;
  logic signed [15:0] left_in, right_in;
  logic        [7:0]  gain;
  logic               mute;
  logic signed [15:0] left, right;
  logic               sample_out, clip;

  int checks = 0;
  int errors = 0;

  longint acc_l_m, acc_r_m;

  jtcps1_snd_mix #(.DCSH(DCSH), .GAINFRAC(GAINFRAC)) dut (
    .clk       (clk),
    .rst       (rst),
    .sample    (sample),
    .left_in   (left_in),
    .right_in  (right_in),
    .gain      (gain),
    .mute      (mute),
    .left      (left),
    .right     (right),
    .sample_out(sample_out),
    .clip      (clip)
  );

  always #10 clk = ~clk;

  // Reference for one channel: y = x - floor(acc/2^DCSH), acc += y (24-bit wrap),
  // out = clamp(floor(y*gain/2^GAINFRAC))
  task automatic model_chan(input int x, input longint acc_in, input int g,
                            output longint acc_out, output int res, output bit ovf);
    longint y, pr, qv, a;
`ifdef JTCPS1_SNDMIX_DCBLOCK_EN
    y = longint'(x) - (acc_in >>> DCSH);
    a = acc_in + y;
    a = a & ((64'sd1 <<< (16+DCSH)) - 1);
    if (a >= (64'sd1 <<< (15+DCSH))) a = a - (64'sd1 <<< (16+DCSH));
    acc_out = a;
`else
    y = longint'(x);
    acc_out = acc_in;
`endif
    pr = y * longint'(g);
    qv = pr >>> GAINFRAC;
    ovf = 1'b0;
    if (qv > 32767) begin qv = 32767; ovf = 1'b1; end
    else if (qv < -32768) begin qv = -32768; ovf = 1'b1; end
    res = int'(qv);
  endtask

  task automatic model_frame(input int l, input int r, input int g, input bit m,
                             output int el, output int er, output bit ec);
    int rl, rr;
    bit ol, orr;
    model_chan(l, acc_l_m, g, acc_l_m, rl, ol);
    model_chan(r, acc_r_m, g, acc_r_m, rr, orr);
    el = m ? 0 : rl;
    er = m ? 0 : rr;
    ec = ol | orr;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; sample = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    acc_l_m = 0;
    acc_r_m = 0;
  endtask

  // One frame: strobe sampled at edge 0, inputs latched at edge 1 and then
  // scrambled, sample_out expected only after edge 6.
  task automatic do_frame(input int l, input int r, input int g, input bit m);
    int el, er;
    bit ec;
    logic [7:0] so;
    logic signed [15:0] gl, gr;
    logic gc;
    model_frame(l, r, g, m, el, er, ec);
    @(negedge clk);
    left_in = 16'(l); right_in = 16'(r); gain = 8'(g); mute = m; sample = 1'b1;
    so = '0; gl = '0; gr = '0; gc = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) sample = 1'b0;
      if (k == 1) begin
        left_in  = 16'($urandom);
        right_in = 16'($urandom);
        gain     = 8'($urandom);
      end
      so[k] = sample_out;
      if (k == 6) begin gl = left; gr = right; gc = clip; end
    end
    checks++;
    if (so !== 8'b0100_0000) begin
      errors++;
      $display("FAIL sample_out_timing: got %b expected %b", so, 8'b0100_0000);
    end
    checks++;
    if (gl !== 16'(el)) begin
      errors++;
      $display("FAIL left: got %0d expected %0d (in %0d gain %0d)", gl, el, l, g);
    end
    checks++;
    if (gr !== 16'(er)) begin
      errors++;
      $display("FAIL right: got %0d expected %0d (in %0d gain %0d)", gr, er, r, g);
    end
    checks++;
    if (gc !== ec) begin
      errors++;
      $display("FAIL clip: got %0b expected %0b", gc, ec);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    checks++;
    if (left !== 16'sd0 || right !== 16'sd0 || sample_out !== 1'b0 || clip !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got l=%0d r=%0d so=%0b clip=%0b expected all 0",
               left, right, sample_out, clip);
    end
  endtask

  task automatic test_basic();
    apply_reset();
    do_frame(1000, -1000, 8'h40, 1'b0);
    do_frame(1000, -1000, 8'h40, 1'b0);
  endtask

  task automatic test_saturation();
    apply_reset();
    do_frame(20000, -20000, 8'h80, 1'b0);
    do_frame(100, -100, 8'h40, 1'b0);
  endtask

  task automatic test_dc_settle();
    int last;
    apply_reset();
    for (int i = 0; i < 4000; i++) do_frame(4096, 0, 8'h40, 1'b0);
    last = int'(left);
    checks++;
`ifdef JTCPS1_SNDMIX_DCBLOCK_EN
    if (last > 16 || last < -16) begin
      errors++;
      $display("FAIL dc_settle: got %0d expected magnitude <= 16", last);
    end
`else
    if (last != 4096) begin
      errors++;
      $display("FAIL dc_passthru: got %0d expected 4096", last);
    end
`endif
  endtask

  task automatic test_floor();
    apply_reset();
    do_frame(-1, 0, 8'h20, 1'b0);
    do_frame(3, 0, 8'h20, 1'b0);
  endtask

  task automatic test_mute_and_gain0();
    apply_reset();
    do_frame(500, -500, 8'h40, 1'b1);
    do_frame(500, -500, 8'h40, 1'b0);
    do_frame(7000, -3000, 8'h00, 1'b0);
    do_frame(7000, -3000, 8'h00, 1'b0);
    do_frame(7000, -3000, 8'h40, 1'b0);
  endtask

  task automatic test_back_to_back();
    int pulses, el, er;
    bit ec;
    apply_reset();
    model_frame(1200, -800, 8'h40, 1'b0, el, er, ec);
    @(negedge clk);
    left_in = 16'sd1200; right_in = -16'sd800; gain = 8'h40; mute = 1'b0;
    sample = 1'b1;
    pulses = 0;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk);
      #1;
      if (k == 0 || k == 3) sample = 1'b0;
      if (k == 2) sample = 1'b1;
      if (sample_out) pulses++;
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL back_to_back_pulses: got %0d expected 1", pulses);
    end
    checks++;
    if (left !== 16'(el) || right !== 16'(er)) begin
      errors++;
      $display("FAIL back_to_back_data: got %0d/%0d expected %0d/%0d", left, right, el, er);
    end
  endtask

  task automatic test_held_high();
    int pulses, el, er;
    bit ec;
    model_frame(-2500, 3300, 8'h50, 1'b0, el, er, ec);
    @(negedge clk);
    left_in = -16'sd2500; right_in = 16'sd3300; gain = 8'h50; mute = 1'b0;
    sample = 1'b1;
    pulses = 0;
    for (int k = 0; k < 24; k++) begin
      @(posedge clk);
      #1;
      if (sample_out) pulses++;
    end
    sample = 1'b0;
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL held_high_pulses: got %0d expected 1", pulses);
    end
    checks++;
    if (left !== 16'(el) || right !== 16'(er)) begin
      errors++;
      $display("FAIL held_high_data: got %0d/%0d expected %0d/%0d", left, right, el, er);
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset_mid_frame();
    int pulses;
    apply_reset();
    do_frame(1500, -700, 8'h40, 1'b0);
    @(negedge clk);
    left_in = 16'sd1234; right_in = -16'sd4321; gain = 8'h40; mute = 1'b0;
    sample = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) sample = 1'b0;
      if (k == 2) rst = 1'b1;
    end
    @(posedge clk);
    #1 rst = 1'b0;
    acc_l_m = 0;
    acc_r_m = 0;
    checks++;
    if (left !== 16'sd0 || right !== 16'sd0 || clip !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_frame_out: got %0d/%0d clip %0b expected 0/0 clip 0",
               left, right, clip);
    end
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (sample_out) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL reset_mid_frame_pulse: got %0d expected 0", pulses);
    end
    do_frame(1000, -1000, 8'h40, 1'b0);
  endtask

  task automatic test_random();
    int l, r, g;
    bit m;
    apply_reset();
    for (int i = 0; i < 300; i++) begin
      l = int'($urandom_range(0, 65535)) - 32768;
      r = int'($urandom_range(0, 65535)) - 32768;
      g = int'($urandom_range(0, 255));
      m = ($urandom_range(0, 7) == 0);
      do_frame(l, r, g, m);
    end
  endtask

  initial begin
    rst = 1'b1; sample = 1'b0; left_in = '0; right_in = '0; gain = '0; mute = 1'b0;
    acc_l_m = 0; acc_r_m = 0;
    test_reset();
    test_basic();
    test_saturation();
    test_floor();
    test_mute_and_gain0();
    test_back_to_back();
    test_held_high();
    test_reset_mid_frame();
    test_random();
    test_dc_settle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
